// File: rtl/renkon_pkg.sv
// Shared defaults, derived pad limit and FSM state type for the renkon datapath.
package renkon_pkg;

    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned LWIDTH_DEF = 10;
    localparam int unsigned MAXFIL_DEF = 5;
    localparam int unsigned MAXPAD     = (MAXFIL_DEF - 1) / 2;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Largest symmetric pad usable with a filter of edge fil.
    function automatic int unsigned pad_of(input int unsigned fil);
        return (fil - 1) / 2;
    endfunction

endpackage

// File: rtl/mem_sp.sv
// Single-port line memory, registered read, write-first on a same-address write.
module mem_sp #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned DEPTH  = 36,
    parameter int unsigned AW     = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic signed [DWIDTH-1:0] wdata,
    output logic signed [DWIDTH-1:0] rdata
);

    logic signed [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/renkon_linebuf_stride.sv
// Padded sliding-window line buffer emitting MAXFIL x MAXFIL windows only at
// stride-aligned positions; two-stage pipeline from scan position to window.
module renkon_linebuf_stride
    import renkon_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned LWIDTH = LWIDTH_DEF,
    parameter int unsigned MAXFIL = MAXFIL_DEF,
    parameter int unsigned MAXIMG = 32,
    parameter int unsigned MAXSTR = 2
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     buf_req,
    input  logic [LWIDTH-1:0]        img_size,
    input  logic [LWIDTH-1:0]        fil_size,
    input  logic [LWIDTH-1:0]        pad_size,
    input  logic [LWIDTH-1:0]        stride,
    input  logic signed [DWIDTH-1:0] buf_input,
    output logic                     buf_ack,
    output logic                     buf_ready,
    output logic                     buf_valid,
    output logic                     buf_last,
    output logic signed [DWIDTH-1:0] buf_output [MAXFIL*MAXFIL]
);

    localparam int unsigned FPAD  = pad_of(MAXFIL);
    localparam int unsigned DEPTH = MAXIMG + 2 * FPAD;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned XW    = LWIDTH + 1;
    localparam int unsigned LSW   = $clog2(MAXFIL);
    localparam int unsigned SW    = $clog2(MAXSTR + 1);
    localparam int unsigned WN    = MAXFIL * MAXFIL;

    state_t state;
    state_t state_n;

    logic [CW-1:0]  row;
    logic [CW-1:0]  col;
    logic [LSW-1:0] lsel;
    logic [SW-1:0]  rph;
    logic [SW-1:0]  cph;
    logic           drain_cnt;

    logic [XW-1:0]  n_x;
    logic [XW-1:0]  f_x;
    logic [XW-1:0]  p_x;
    logic [XW-1:0]  s_x;
    logic [XW-1:0]  pdim;
    logic [XW-1:0]  row_x;
    logic [XW-1:0]  col_x;
    int             fil_i;

    logic           start_c;
    logic           scan_c;
    logic           row_last_c;
    logic           col_last_c;
    logic           in_img_c;
    logic           emit_c;
    logic           last_c;
    logic [SW-1:0]  rph_adv_c;
    logic [SW-1:0]  cph_adv_c;
    logic [LSW-1:0] lsel_adv_c;
    logic signed [DWIDTH-1:0] wdata_c;

    logic           scan1;
    logic           emit1;
    logic           last1;
    logic [LSW-1:0] lsel1;

    logic signed [DWIDTH-1:0] q      [MAXFIL];
    logic signed [DWIDTH-1:0] colv_c [MAXFIL];
    logic signed [DWIDTH-1:0] win_n  [WN];

    // Config zero-extended so every comparison happens at LWIDTH+1 bits.
    always_comb begin
        n_x   = XW'(img_size);
        f_x   = XW'(fil_size);
        p_x   = XW'(pad_size);
        s_x   = (stride == '0) ? XW'(1) : XW'(stride);
        pdim  = n_x + (p_x << 1);
        row_x = XW'(row);
        col_x = XW'(col);
        fil_i = int'(f_x);
    end

    // Position decode: image/pad, end of line/frame, window emission.
    always_comb begin
        row_last_c = (row_x == pdim - XW'(1));
        col_last_c = (col_x == pdim - XW'(1));
        in_img_c   = (row_x >= p_x) && (row_x < p_x + n_x) &&
                     (col_x >= p_x) && (col_x < p_x + n_x);
        emit_c     = scan_c && (row_x >= f_x - XW'(1)) && (col_x >= f_x - XW'(1)) &&
                     (rph == '0) && (cph == '0);
        // Last window: no further stride-aligned row or column fits in the frame.
        last_c     = emit_c && (row_x + s_x >= pdim) && (col_x + s_x >= pdim);
        buf_ready  = scan_c && in_img_c;
        wdata_c    = buf_ready ? buf_input : '0;
    end

    // Stride phase counters start wrapping once the first full window fits.
    always_comb begin
        if (row_x + XW'(1) < f_x) begin
            rph_adv_c = '0;
        end else if (XW'(rph) == s_x - XW'(1)) begin
            rph_adv_c = '0;
        end else begin
            rph_adv_c = rph + SW'(1);
        end
        if (col_x + XW'(1) < f_x) begin
            cph_adv_c = '0;
        end else if (XW'(cph) == s_x - XW'(1)) begin
            cph_adv_c = '0;
        end else begin
            cph_adv_c = cph + SW'(1);
        end
        lsel_adv_c = (lsel == LSW'(MAXFIL - 1)) ? '0 : lsel + LSW'(1);
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_WAIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        start_c = 1'b0;
        scan_c  = 1'b0;
        case (state)
            S_WAIT: begin
                if (buf_req) begin
                    state_n = S_SCAN;
                    start_c = 1'b1;
                end
            end
            S_SCAN: begin
                scan_c = 1'b1;
                if (row_last_c && col_last_c) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt) begin
                    state_n = S_WAIT;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    // Raster position, line rotation and stride phase.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            row       <= '0;
            col       <= '0;
            lsel      <= '0;
            rph       <= '0;
            cph       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            if (start_c) begin
                row  <= '0;
                col  <= '0;
                lsel <= '0;
                rph  <= '0;
                cph  <= '0;
            end else if (scan_c) begin
                if (col_last_c) begin
                    col <= '0;
                    cph <= '0;
                    if (!row_last_c) begin
                        row  <= row + CW'(1);
                        rph  <= rph_adv_c;
                        lsel <= lsel_adv_c;
                    end
                end else begin
                    col <= col + CW'(1);
                    cph <= cph_adv_c;
                end
            end
        end
    end

    for (genvar k = 0; k < MAXFIL; k++) begin : g_line
        mem_sp #(
            .DWIDTH(DWIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_line (
            .clk  (clk),
            .we   (scan_c && (lsel == LSW'(k))),
            .addr (AW'(col)),
            .wdata(wdata_c),
            .rdata(q[k])
        );
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            scan1 <= 1'b0;
            emit1 <= 1'b0;
            last1 <= 1'b0;
            lsel1 <= '0;
        end else begin
            scan1 <= scan_c;
            emit1 <= emit_c;
            last1 <= last_c;
            lsel1 <= lsel;
        end
    end

    // Window row i (top = 0) is padded row r-F+1+i, held F-1-i lines behind lsel.
    always_comb begin
        int idx;
        idx = 0;
        for (int i = 0; i < int'(MAXFIL); i++) begin
            colv_c[i] = '0;
            if (i < fil_i) begin
                idx = int'(lsel1) + int'(MAXFIL) - (fil_i - 1 - i);
                if (idx >= int'(MAXFIL)) begin
                    idx = idx - int'(MAXFIL);
                end
                colv_c[i] = q[LSW'(idx)];
            end
        end
    end

    // Left shift within the F x F region; new column enters at column F-1.
    always_comb begin
        for (int k = 0; k < int'(WN); k++) begin
            win_n[k] = '0;
        end
        for (int i = 0; i < int'(MAXFIL); i++) begin
            for (int j = 0; j < int'(MAXFIL) - 1; j++) begin
                if (j + 1 < fil_i) begin
                    win_n[int'(MAXFIL) * i + j] = buf_output[int'(MAXFIL) * i + j + 1];
                end
            end
            for (int j = 0; j < int'(MAXFIL); j++) begin
                if (j + 1 == fil_i) begin
                    win_n[int'(MAXFIL) * i + j] = colv_c[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            buf_ack   <= 1'b1;
            buf_valid <= 1'b0;
            buf_last  <= 1'b0;
            for (int k = 0; k < int'(WN); k++) begin
                buf_output[k] <= '0;
            end
        end else begin
            buf_ack   <= (state_n == S_WAIT);
            buf_valid <= emit1;
            buf_last  <= last1;
            if (scan1) begin
                for (int k = 0; k < int'(WN); k++) begin
                    buf_output[k] <= win_n[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_renkon_linebuf_stride.sv
// Bench for renkon_linebuf_stride: window-enumeration model plus literal pins.
module tb_renkon_linebuf_stride;

    localparam int MF  = 5;
    localparam int WN  = MF * MF;
    localparam int SCH = 1400;

    logic              clk = 1'b0;
    logic              xrst = 1'b1;
    logic              buf_req = 1'b0;
    logic [9:0]        img_size = '0;
    logic [9:0]        fil_size = '0;
    logic [9:0]        pad_size = '0;
    logic [9:0]        stride = '0;
    logic signed [15:0] buf_input = '0;
    logic              buf_ack;
    logic              buf_ready;
    logic              buf_valid;
    logic              buf_last;
    logic signed [15:0] buf_output [WN];

    renkon_linebuf_stride dut (
        .clk       (clk),
        .xrst      (xrst),
        .buf_req   (buf_req),
        .img_size  (img_size),
        .fil_size  (fil_size),
        .pad_size  (pad_size),
        .stride    (stride),
        .buf_input (buf_input),
        .buf_ack   (buf_ack),
        .buf_ready (buf_ready),
        .buf_valid (buf_valid),
        .buf_last  (buf_last),
        .buf_output(buf_output)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cfg_n, cfg_f, cfg_p, cfg_s, cfg_pd, qn;
    int pix [1024];
    bit exp_valid [SCH];
    int exp_qr [SCH];
    int exp_qc [SCH];

    bit mon_on = 1'b0;
    int base = 0;
    int pidx = 0;

    int nwin, first_off, acklow, last_idx;
    bit last_seen;
    int woff [4];
    int win_cap [3][WN];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int padval(input int r, input int c);
        if (r >= cfg_p && r < cfg_p + cfg_n && c >= cfg_p && c < cfg_p + cfg_n)
            return pix[(r - cfg_p) * cfg_n + (c - cfg_p)];
        return 0;
    endfunction

    // Enumerate output windows by (qr,qc); each appears two cycles after its corner is scanned.
    task automatic build_model(input int n, input int f, input int p, input int s);
        int corner;
        cfg_n = n; cfg_f = f; cfg_p = p; cfg_s = s;
        cfg_pd = n + 2 * p;
        qn = (cfg_pd - f) / s + 1;
        for (int k = 0; k < SCH; k++) exp_valid[k] = 1'b0;
        for (int qr = 0; qr < qn; qr++) begin
            for (int qc = 0; qc < qn; qc++) begin
                corner = (qr * s + f - 1) * cfg_pd + (qc * s + f - 1);
                exp_valid[corner + 2] = 1'b1;
                exp_qr[corner + 2] = qr;
                exp_qc[corner + 2] = qc;
            end
        end
        img_size = 10'(n); fil_size = 10'(f); pad_size = 10'(p); stride = 10'(s);
    endtask

    task automatic clear_stats();
        nwin = 0; first_off = -1; acklow = 0; last_idx = -1; last_seen = 1'b0;
        for (int k = 0; k < 4; k++) woff[k] = -1;
    endtask

    // Pixel producer: a new pixel whenever the DUT consumes one.
    initial begin
        forever begin
            @(negedge clk);
            if (buf_ready && pidx < 1024) begin
                buf_input = 16'(pix[pidx]);
                pidx++;
            end
        end
    end

    // Per-cycle compare against the model while a frame is monitored.
    always @(negedge clk) begin
        int off, r, c, e, a, bad, ba, be;
        bit ev, er;
        if (mon_on) begin
            off = cyc - base;
            check("buf_ack", int'(buf_ack), int'(off >= cfg_pd * cfg_pd + 2));
            er = 1'b0;
            if (off < cfg_pd * cfg_pd) begin
                r = off / cfg_pd; c = off % cfg_pd;
                er = (r >= cfg_p && r < cfg_p + cfg_n && c >= cfg_p && c < cfg_p + cfg_n);
            end
            check("buf_ready", int'(buf_ready), int'(er));
            ev = (off >= 0 && off < SCH) ? exp_valid[off] : 1'b0;
            check("buf_valid", int'(buf_valid), int'(ev));
            if (!buf_ack) acklow++;
            if (buf_valid && ev) begin
                check("buf_last", int'(buf_last),
                      int'(exp_qr[off] == qn - 1 && exp_qc[off] == qn - 1));
                bad = -1; ba = 0; be = 0;
                for (int i = 0; i < MF; i++) begin
                    for (int j = 0; j < MF; j++) begin
                        e = (i < cfg_f && j < cfg_f) ?
                            padval(exp_qr[off] * cfg_s + i, exp_qc[off] * cfg_s + j) : 0;
                        a = int'(buf_output[MF * i + j]);
                        if (a != e && bad < 0) begin bad = MF * i + j; ba = a; be = e; end
                    end
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL window elem %0d got %0d exp %0d (off %0d)", bad, ba, be, off);
                end
                if (nwin == 0) first_off = off;
                if (nwin < 4) woff[nwin] = off;
                if (nwin < 2) for (int k = 0; k < WN; k++) win_cap[nwin][k] = int'(buf_output[k]);
                if (buf_last) begin
                    last_seen = 1'b1;
                    last_idx = nwin;
                    for (int k = 0; k < WN; k++) win_cap[2][k] = int'(buf_output[k]);
                end
                nwin++;
            end
        end else if (xrst) begin
            check("idle_valid", int'(buf_valid), 0);
        end
    end

    task automatic frame_stats();
        check("window_count", nwin, qn * qn);
        check("ack_low_cycles", acklow, cfg_pd * cfg_pd + 2);
        check("last_index", last_idx, qn * qn - 1);
    endtask

    // Runs nframes frames; with hold, buf_req stays high between them.
    task automatic run_frames(input bit hold, input int nframes);
        int t;
        t = 0;
        while (!buf_ack && t < 100) begin @(posedge clk); #1; t++; end
        check("ack_before_req", int'(buf_ack), 1);
        buf_req = 1'b1;
        @(posedge clk); #1;
        base = cyc; pidx = 0; clear_stats(); mon_on = 1'b1;
        if (!hold) buf_req = 1'b0;
        for (int fr = 0; fr < nframes; fr++) begin
            repeat (cfg_pd * cfg_pd + 2) @(posedge clk);
            #1;
            if (fr == nframes - 1) buf_req = 1'b0;
            @(posedge clk); #1;
            frame_stats();
            if (fr < nframes - 1) begin
                base = cyc; pidx = 0; clear_stats();
            end
        end
        mon_on = 1'b0;
    endtask

    task automatic check_lit(input string name, input int slot, input int lit [9]);
        int bad;
        bad = -1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (win_cap[slot][MF * i + j] != lit[3 * i + j] && bad < 0) bad = 3 * i + j;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s elem %0d got %0d exp %0d", name, bad,
                     win_cap[slot][MF * (bad / 3) + bad % 3], lit[bad]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz;
        nz = 0;
        for (int k = 0; k < WN; k++) if (buf_output[k] != 0) nz++;
        check({tag, "_ack"}, int'(buf_ack), 1);
        check({tag, "_ready"}, int'(buf_ready), 0);
        check({tag, "_valid"}, int'(buf_valid), 0);
        check({tag, "_last"}, int'(buf_last), 0);
        check({tag, "_output_nonzero"}, nz, 0);
    endtask

    initial begin
        int lit_a [9];
        int lit_b [9];
        int lit_c [9];
        #2 xrst = 1'b0;
        #1 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        xrst = 1'b1;
        @(posedge clk); #1;

        // N=4 F=3 p=1 s=1, pixels 1..16
        for (int k = 0; k < 1024; k++) pix[k] = k + 1;
        build_model(4, 3, 1, 1);
        run_frames(1'b0, 1);
        check("t1_first_off", first_off, 16);
        check("t1_count", nwin, 16);
        lit_a = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
        check_lit("t1_first_window", 0, lit_a);
        lit_b = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
        check_lit("t1_last_window", 2, lit_b);
        check("t1_last_seen", int'(last_seen), 1);

        // Same image, stride 2
        build_model(4, 3, 1, 2);
        run_frames(1'b0, 1);
        check("t2_count", nwin, 4);
        check("t2_off0", woff[0], 16);
        check("t2_off1", woff[1], 18);
        check("t2_off2", woff[2], 28);
        check("t2_off3", woff[3], 30);
        lit_c = '{0, 0, 0, 2, 3, 4, 6, 7, 8};
        check_lit("t2_second_window", 1, lit_c);

        // N=5 F=1 p=0 s=1, signed pixels
        for (int k = 0; k < 25; k++) pix[k] = 100 * k - 700;
        build_model(5, 1, 0, 1);
        run_frames(1'b0, 1);
        check("t3_count", nwin, 25);
        check("t3_ack_low", acklow, 27);
        check("t3_first_pixel", win_cap[0][0], -700);

        // Max config N=32 F=5 p=2 s=2, random signed pixels
        for (int k = 0; k < 1024; k++) pix[k] = int'($urandom_range(0, 65535)) - 32768;
        build_model(32, 5, 2, 2);
        run_frames(1'b0, 1);
        check("t4_count", nwin, 256);

        // Back-to-back frames with buf_req held high
        for (int k = 0; k < 1024; k++) pix[k] = k + 1;
        build_model(4, 3, 1, 1);
        run_frames(1'b1, 2);
        check("t5_second_first_off", first_off, 16);
        check_lit("t5_second_last_window", 2, lit_b);

        // Reset in the middle of a scan, then a clean frame
        build_model(4, 3, 1, 1);
        buf_req = 1'b1;
        @(posedge clk); #1;
        base = cyc; pidx = 0; clear_stats(); mon_on = 1'b1;
        buf_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        mon_on = 1'b0;
        xrst = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk); @(posedge clk); #1;
        xrst = 1'b1;
        @(posedge clk); #1;
        build_model(4, 3, 1, 2);
        run_frames(1'b0, 1);
        check("t6_count", nwin, 4);
        check_lit("t6_second_window", 1, lit_c);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
